gol_run_controller: RTL and testbench
=====================================

Name: gol_run_controller

Overview:
- Sequences the Game of Life engine through N consecutive generations without HPS involvement per generation.
- Ping-pongs the engine's start/result buffer addresses between two on-chip memory regions.
- Issues one launch per generation and counts completions.
- Reports busy/done/abort/timeout status and the final result address to the HPS PIO side.
- Sits between the HPS PIO exports and the engine wrapper's start/address/completed/reset pins.

Parameters:
- ADDR_W, 12, width of on-chip memory byte address.
- GEN_W, 16, width of generation count.
- BUF_A_BASE, 12'h000, base address of buffer A (initial board).
- BUF_B_BASE, 12'h100, base address of buffer B.
- RESET_CYCLES, 4, cycles eng_reset is held after an abort (min 1).
- TIMEOUT_CYCLES, 1048576, max WAIT cycles per generation (used only with GOL_RUN_TIMEOUT_EN).

Ports:
- clock  in  1  system clock (fpga_clk_50 domain).
- reset_n  in  1  asynchronous active-low reset.
- cmd_run  in  1  HPS run request; rising edge starts a run.
- cmd_abort  in  1  HPS abort, level-sensitive.
- cmd_generations  in  GEN_W  generation count N, sampled on the cmd_run rising edge.
- eng_start_addr  out  ADDR_W  source board address to engine.
- eng_result_addr  out  ADDR_W  destination board address to engine.
- eng_go  out  1  one-cycle launch pulse to engine.
- eng_done  in  1  engine completed level; rising edge = generation finished.
- eng_reset  out  1  active-high synchronous reset to engine.
- busy  out  1  run in progress.
- done  out  1  sticky run-complete flag.
- aborted  out  1  sticky abort flag.
- timeout  out  1  sticky timeout flag.
- gen_count  out  GEN_W  generations completed in the current/last run.
- final_addr  out  ADDR_W  buffer holding the latest completed board.

Behaviour:
- Reset values: state=IDLE, all 1-bit outputs 0, gen_count=0, eng_start_addr=final_addr=BUF_A_BASE, eng_result_addr=BUF_B_BASE.
- Edge detectors: cmd_run and eng_done are registered one stage; an edge is prev=0 and cur=1. Edge-to-action latency is 1 cycle.
- States: IDLE, LAUNCH, WAIT, SWAP, FINISH, ABORT.
- IDLE, on run edge:
  - Clear done, aborted, timeout and gen_count.
  - Set src=A, dst=B, latch N.
  - If N==0: go FINISH with final_addr=BUF_A_BASE.
  - Otherwise: go LAUNCH.
- LAUNCH: eng_go=1 for exactly this cycle, then go WAIT. busy=1 in every state except IDLE.
- WAIT, on eng_done edge:
  - gen_count+1 and final_addr=dst.
  - If the new gen_count equals N: go FINISH.
  - Otherwise: go SWAP.
- SWAP: exchange eng_start_addr and eng_result_addr (1 cycle), then go LAUNCH.
  - Turnaround from eng_done edge to next eng_go is 3 cycles.
- FINISH: set done=1, go IDLE.
- Address stability: the engine address outputs change only in IDLE (run start) or SWAP.
- Abort: cmd_abort=1 in any non-IDLE state goes to ABORT next cycle.
  - Abort has priority over a simultaneous eng_done edge; that generation is not counted.
  - ABORT holds eng_reset=1 for RESET_CYCLES cycles, then sets aborted=1 and goes IDLE.
  - gen_count and final_addr keep their last valid values.
  - cmd_abort in IDLE is ignored.
- Run edge while busy: ignored. It is not queued.
- eng_done high at run start: no edge, so it is not counted. An edge requires eng_done to fall and rise again.
- Widths: gen_count never exceeds N, so no wrap. N=2^GEN_W-1 is legal.

Optional Feature:
- Macro: GOL_RUN_TIMEOUT_EN.
- When defined:
  - A 21-bit cycle counter clears in LAUNCH and increments in WAIT.
  - Reaching TIMEOUT_CYCLES-1 without an eng_done edge sets timeout=1 and enters ABORT. aborted is also set.
  - An eng_done edge on the same cycle as expiry wins: the generation counts and no timeout occurs.
- When undefined: no counter is synthesised, timeout is tied to 0, and WAIT waits indefinitely.

Test Plan:
- N=3, eng_done pulses 5 cycles after each eng_go:
  - Exactly 3 eng_go pulses.
  - Address pairs are (000→100), (100→000), (000→100).
  - Result: gen_count=3, final_addr=12'h100, done=1, busy=0.
- N=2: final_addr=12'h000, done=1.
- N=0: done=1 within 3 cycles of the run edge, no eng_go, gen_count=0, final_addr=12'h000.
- N=5, cmd_abort asserted in WAIT of generation 2, on the same cycle as an eng_done edge:
  - eng_reset high for 4 cycles.
  - Result: aborted=1, gen_count=1, done=0, then IDLE.
- Second cmd_run edge mid-run: ignored, the run completes normally. A new run edge afterwards clears done and restarts from buffer A.
- With GOL_RUN_TIMEOUT_EN and TIMEOUT_CYCLES=16, engine never responds:
  - Result: timeout=1 and aborted=1 about 17 cycles after eng_go, gen_count=0.
- Async reset mid-WAIT: all outputs return to their reset values immediately, without a clock edge.

Source files
------------

// File: rtl/gol_run_controller.sv
// Runs the Game of Life engine through N generations, swapping source and result buffers after each one.
// Define GOL_RUN_TIMEOUT_EN to add a per-generation WAIT timeout.
module gol_run_controller #(
    parameter int                ADDR_W         = 12,
    parameter int                GEN_W          = 16,
    parameter logic [ADDR_W-1:0] BUF_A_BASE     = 12'h000,
    parameter logic [ADDR_W-1:0] BUF_B_BASE     = 12'h100,
    parameter int                RESET_CYCLES   = 4,
    parameter int                TIMEOUT_CYCLES = 1048576
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_run,
    input  logic              cmd_abort,
    input  logic [GEN_W-1:0]  cmd_generations,
    output logic [ADDR_W-1:0] eng_start_addr,
    output logic [ADDR_W-1:0] eng_result_addr,
    output logic              eng_go,
    input  logic              eng_done,
    output logic              eng_reset,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              timeout,
    output logic [GEN_W-1:0]  gen_count,
    output logic [ADDR_W-1:0] final_addr
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        SWAP,
        FINISH,
        ABORT
    } state_t;

    localparam int              RC_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             run_cur;
    logic             run_prev;
    logic             done_cur;
    logic             done_prev;
    logic             run_edge;
    logic             done_edge;
    logic [GEN_W-1:0] n_lat;
    logic [RC_W-1:0]  rst_cnt;
    logic             rst_last;
    logic             last_gen;
    logic             tmo_hit;

    assign run_edge  = run_cur & ~run_prev;
    assign done_edge = done_cur & ~done_prev;
    assign rst_last  = (rst_cnt == RC_LAST);
    assign last_gen  = ((gen_count + GEN_W'(1)) == n_lat);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_cur   <= 1'b0;
            run_prev  <= 1'b0;
            done_cur  <= 1'b0;
            done_prev <= 1'b0;
        end else begin
            run_cur   <= cmd_run;
            run_prev  <= run_cur;
            done_cur  <= eng_done;
            done_prev <= done_cur;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        eng_go    = (state == LAUNCH);
        eng_reset = (state == ABORT);
        busy      = (state != IDLE);
        if (cmd_abort && state != IDLE && state != ABORT) begin
            state_nxt = ABORT;
        end else begin
            case (state)
                IDLE:    if (run_edge) state_nxt = (cmd_generations == '0) ? FINISH : LAUNCH;
                LAUNCH:  state_nxt = WAIT;
                WAIT: begin
                    if (done_edge)    state_nxt = last_gen ? FINISH : SWAP;
                    else if (tmo_hit) state_nxt = ABORT;
                end
                SWAP:    state_nxt = LAUNCH;
                FINISH:  state_nxt = IDLE;
                ABORT:   if (rst_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt <= '0;
        end else if (state == ABORT) begin
            rst_cnt <= rst_cnt + RC_W'(1);
        end else begin
            rst_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done            <= 1'b0;
            aborted         <= 1'b0;
            gen_count       <= '0;
            n_lat           <= '0;
            eng_start_addr  <= BUF_A_BASE;
            eng_result_addr <= BUF_B_BASE;
            final_addr      <= BUF_A_BASE;
        end else begin
            case (state)
                IDLE: begin
                    if (run_edge) begin
                        done            <= 1'b0;
                        aborted         <= 1'b0;
                        gen_count       <= '0;
                        n_lat           <= cmd_generations;
                        eng_start_addr  <= BUF_A_BASE;
                        eng_result_addr <= BUF_B_BASE;
                        final_addr      <= BUF_A_BASE;
                    end
                end
                WAIT: begin
                    // An abort on the same cycle discards the completing generation.
                    if (done_edge && !cmd_abort) begin
                        gen_count  <= gen_count + GEN_W'(1);
                        final_addr <= eng_result_addr;
                    end
                end
                SWAP: begin
                    eng_start_addr  <= eng_result_addr;
                    eng_result_addr <= eng_start_addr;
                end
                FINISH:  if (!cmd_abort) done <= 1'b1;
                ABORT:   if (rst_last) aborted <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef GOL_RUN_TIMEOUT_EN
    localparam logic [20:0] TMO_LAST = 21'(TIMEOUT_CYCLES - 1);

    logic [20:0] tmo_cnt;

    assign tmo_hit = (state == WAIT) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == LAUNCH)    tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + 21'd1;

            if (state == IDLE && run_edge)               timeout <= 1'b0;
            else if (tmo_hit && !done_edge && !cmd_abort) timeout <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gol_run_controller.sv
// Self-checking bench for gol_run_controller: directed runs plus randomized generation counts and engine latencies.
module tb_gol_run_controller;

    localparam int          ADDR_W       = 12;
    localparam int          GEN_W        = 16;
    localparam int          RESET_CYCLES = 4;
    localparam logic [11:0] BUF_A        = 12'h000;
    localparam logic [11:0] BUF_B        = 12'h100;
`ifdef GOL_RUN_TIMEOUT_EN
    localparam int          TIMEOUT_CYCLES = 16;
`else
    localparam int          TIMEOUT_CYCLES = 1048576;
`endif

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_run = 1'b0;
    logic              cmd_abort = 1'b0;
    logic [GEN_W-1:0]  cmd_generations = '0;
    logic              eng_done = 1'b0;
    logic [ADDR_W-1:0] eng_start_addr;
    logic [ADDR_W-1:0] eng_result_addr;
    logic              eng_go;
    logic              eng_reset;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              timeout;
    logic [GEN_W-1:0]  gen_count;
    logic [ADDR_W-1:0] final_addr;

    int errors = 0;
    int checks = 0;

    // Per-run observations filled in by do_run
    logic [11:0] go_src[$];
    logic [11:0] go_dst[$];
    int          go_k[$];
    int          rise_k[$];
    int          rst_seen;
    int          first_done_k;
    logic        busy_k2;
    logic        done_k3;

    gol_run_controller #(
        .ADDR_W        (ADDR_W),
        .GEN_W         (GEN_W),
        .BUF_A_BASE    (BUF_A),
        .BUF_B_BASE    (BUF_B),
        .RESET_CYCLES  (RESET_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cmd_run        (cmd_run),
        .cmd_abort      (cmd_abort),
        .cmd_generations(cmd_generations),
        .eng_start_addr (eng_start_addr),
        .eng_result_addr(eng_result_addr),
        .eng_go         (eng_go),
        .eng_done       (eng_done),
        .eng_reset      (eng_reset),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .timeout        (timeout),
        .gen_count      (gen_count),
        .final_addr     (final_addr)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: generation i reads buffer A when i is even, so the board after g generations sits in A iff g is even.
    function automatic logic [11:0] board_after(input int g);
        return (g % 2 == 0) ? BUF_A : BUF_B;
    endfunction

    function automatic logic [11:0] other_buf(input logic [11:0] b);
        return (b == BUF_A) ? BUF_B : BUF_A;
    endfunction

    task automatic wait_go(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            if (eng_go) ok = 1'b1;
        end
    endtask

    // One run with a cycle-level engine model; lat_fixed=0 draws a random latency per generation.
    task automatic do_run(input int n, input int lat_fixed, input int abort_gen, input int reedge_k);
        int k;
        int cd;
        int hold;
        int ndone;
        bit abort_now;
        bit finished;
        go_src.delete();
        go_dst.delete();
        go_k.delete();
        rise_k.delete();
        rst_seen     = 0;
        first_done_k = -1;
        busy_k2      = 1'bx;
        done_k3      = 1'bx;
        @(negedge clock);
        cmd_run         = 1'b0;
        cmd_generations = GEN_W'(n);
        @(negedge clock);
        cmd_run   = 1'b1;
        k         = 0;
        cd        = 0;
        hold      = 0;
        ndone     = 0;
        abort_now = 1'b0;
        finished  = 1'b0;
        while (!finished && k < 3000) begin
            @(negedge clock);
            k++;
            if (eng_go) begin
                go_src.push_back(eng_start_addr);
                go_dst.push_back(eng_result_addr);
                go_k.push_back(k);
            end
            if (eng_reset) rst_seen++;
            if (k >= 2 && done && first_done_k < 0) first_done_k = k;
            if (k == 2) busy_k2 = busy;
            if (k == 3) done_k3 = done;
            cmd_abort = abort_now;
            abort_now = 1'b0;
            if (k == 3) cmd_run = 1'b0;
            if (reedge_k > 0 && k == reedge_k) cmd_run = 1'b1;
            if (hold > 0) begin
                hold--;
                if (hold == 0) eng_done = 1'b0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eng_done = 1'b1;
                    hold     = 2;
                    ndone++;
                    rise_k.push_back(k);
                    if (ndone == abort_gen) abort_now = 1'b1;
                end
            end
            if (eng_go) cd = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 8));
            if (k >= 4 && !busy && cd == 0 && hold == 0) finished = 1'b1;
        end
        check("run_bounded", 32'(finished), 32'd1);
    endtask

    task automatic eval_run(input string tag, input int n, input int abort_gen);
        int g;
        int gos;
        bit ab;
        ab  = (abort_gen > 0);
        g   = ab ? abort_gen - 1 : n;
        gos = ab ? abort_gen : n;
        check({tag, "_go_count"}, 32'(go_src.size()), 32'(gos));
        for (int i = 0; i < gos && i < go_src.size(); i++) begin
            check($sformatf("%s_src%0d", tag, i), 32'(go_src[i]), 32'(board_after(i)));
            check($sformatf("%s_dst%0d", tag, i), 32'(go_dst[i]), 32'(other_buf(board_after(i))));
        end
        for (int i = 1; i < go_k.size() && i <= rise_k.size(); i++)
            check($sformatf("%s_turnaround%0d", tag, i), 32'(go_k[i] - rise_k[i-1]), 32'd3);
        if (n > 0) begin
            check({tag, "_first_go"}, 32'(go_k.size() > 0 ? go_k[0] : -1), 32'd2);
            check({tag, "_busy_k2"}, 32'(busy_k2), 32'd1);
            check({tag, "_done_cleared"}, 32'(done_k3), 32'd0);
        end else begin
            check({tag, "_done_within3"}, 32'(first_done_k >= 2 && first_done_k <= 3), 32'd1);
        end
        check({tag, "_gen_count"}, 32'(gen_count), 32'(g));
        check({tag, "_final_addr"}, 32'(final_addr), 32'(board_after(g)));
        check({tag, "_done"}, 32'(done), 32'(!ab));
        check({tag, "_aborted"}, 32'(aborted), 32'(ab));
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_eng_reset_cycles"}, 32'(rst_seen), ab ? 32'(RESET_CYCLES) : 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_aborted"}, 32'(aborted), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_eng_go"}, 32'(eng_go), 32'd0);
        check({tag, "_eng_reset"}, 32'(eng_reset), 32'd0);
        check({tag, "_gen_count"}, 32'(gen_count), 32'd0);
        check({tag, "_start_addr"}, 32'(eng_start_addr), 32'(BUF_A));
        check({tag, "_result_addr"}, 32'(eng_result_addr), 32'(BUF_B));
        check({tag, "_final_addr"}, 32'(final_addr), 32'(BUF_A));
    endtask

    initial begin
        bit ok;
        int n;
        int t;

        #35;
        check_reset_values("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Abort while idle has no effect
        @(negedge clock);
        cmd_abort = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_eng_reset", 32'(eng_reset), 32'd0);
        check("idle_abort_aborted", 32'(aborted), 32'd0);
        cmd_abort = 1'b0;

        do_run(3, 5, 0, 0);
        eval_run("n3", 3, 0);
        do_run(2, 5, 0, 0);
        eval_run("n2", 2, 0);
        do_run(0, 5, 0, 0);
        eval_run("n0", 0, 0);
        do_run(5, 5, 2, 0);
        eval_run("abort", 5, 2);
        do_run(3, 5, 0, 10);
        eval_run("reedge", 3, 0);
        do_run(4, 0, 0, 0);
        eval_run("after_reedge", 4, 0);

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 9));
            do_run(n, 0, 0, 0);
            eval_run($sformatf("rand%0d", r), n, 0);
        end
        for (int r = 0; r < 2; r++) begin
            n = int'($urandom_range(3, 6));
            t = int'($urandom_range(2, n));
            do_run(n, 0, t, 0);
            eval_run($sformatf("rand_abort%0d", r), n, t);
        end

`ifdef GOL_RUN_TIMEOUT_EN
        // Engine never answers: expiry after TIMEOUT_CYCLES WAIT cycles
        @(negedge clock);
        cmd_run         = 1'b0;
        cmd_generations = GEN_W'(1);
        @(negedge clock);
        cmd_run = 1'b1;
        wait_go(ok);
        check("tmo_go_seen", 32'(ok), 32'd1);
        cmd_run = 1'b0;
        t = 0;
        while (!timeout && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("tmo_latency", 32'(t), 32'(TIMEOUT_CYCLES + 1));
        t = 0;
        while (busy && t < 20) begin
            @(negedge clock);
            t++;
        end
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_timeout", 32'(timeout), 32'd1);
        check("tmo_aborted", 32'(aborted), 32'd1);
        check("tmo_gen_count", 32'(gen_count), 32'd0);
        check("tmo_done", 32'(done), 32'd0);
`endif

        // Asynchronous reset in WAIT of generation 2
        @(negedge clock);
        cmd_run         = 1'b0;
        cmd_generations = GEN_W'(3);
        @(negedge clock);
        cmd_run = 1'b1;
        wait_go(ok);
        check("ar_go1", 32'(ok), 32'd1);
        cmd_run = 1'b0;
        repeat (3) @(negedge clock);
        eng_done = 1'b1;
        repeat (2) @(negedge clock);
        eng_done = 1'b0;
        wait_go(ok);
        check("ar_go2", 32'(ok), 32'd1);
        repeat (2) @(negedge clock);
        check("ar_pre_gen_count", 32'(gen_count), 32'd1);
        check("ar_pre_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
